// File: rtl/ctrl_pipe_unit_if.sv
// Control-pipeline bus: ID-stage inputs, flush, and the per-stage control outputs.
// Parameters must match those given to ctrl_pipe_unit.
interface ctrl_pipe_unit_if #(
    parameter int ALUOP_W    = 2,
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid_i;
    logic [6:0]            opcode_id_i;
    logic [REG_ADDR_W-1:0] rs1_id_i;
    logic [REG_ADDR_W-1:0] rs2_id_i;
    logic [REG_ADDR_W-1:0] rd_id_i;
    logic                  flush_i;
    logic                  stall_o;
    logic [ALUOP_W-1:0]    ex_aluop_o;
    logic                  ex_alusrc_o;
    logic [REG_ADDR_W-1:0] ex_rd_o;
    logic                  mem_branch_o;
    logic                  mem_memread_o;
    logic                  mem_memwrite_o;
    logic [REG_ADDR_W-1:0] mem_rd_o;
    logic [REG_ADDR_W-1:0] wb_rd_o;
    logic                  mem_regwrite_o;
    logic                  wb_regwrite_o;
    logic                  wb_memtoreg_o;
    logic                  wb_valid_o;
    logic                  wb_illegal_o;
    logic                  illegal_sticky_o;

    modport master (
        output id_valid_i, opcode_id_i, rs1_id_i, rs2_id_i, rd_id_i, flush_i,
        input  stall_o, ex_aluop_o, ex_alusrc_o, ex_rd_o,
               mem_branch_o, mem_memread_o, mem_memwrite_o, mem_rd_o, wb_rd_o,
               mem_regwrite_o, wb_regwrite_o, wb_memtoreg_o, wb_valid_o,
               wb_illegal_o, illegal_sticky_o
    );

    modport slave (
        input  id_valid_i, opcode_id_i, rs1_id_i, rs2_id_i, rd_id_i, flush_i,
        output stall_o, ex_aluop_o, ex_alusrc_o, ex_rd_o,
               mem_branch_o, mem_memread_o, mem_memwrite_o, mem_rd_o, wb_rd_o,
               mem_regwrite_o, wb_regwrite_o, wb_memtoreg_o, wb_valid_o,
               wb_illegal_o, illegal_sticky_o
    );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// Pipelined main control: ID decode, load-use stall, ID/EX, EX/MEM, MEM/WB control registers.
// Optional macro ILLEGAL_OP_EN carries an illegal-opcode flag to WB with a sticky flag.
module ctrl_pipe_unit #(
    parameter int ALUOP_W        = 2,
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_USE_STALL = 1
) (
    input logic             clk,
    input logic             rst_n,
    ctrl_pipe_unit_if.slave bus
);
    typedef struct packed {
        logic [ALUOP_W-1:0]    aluop;
        logic                  alusrc;
        logic                  branch;
        logic                  memread;
        logic                  memwrite;
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] rd;
        logic                  valid;
    } ex_ctrl_t;

    typedef struct packed {
        logic                  branch;
        logic                  memread;
        logic                  memwrite;
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] rd;
        logic                  valid;
    } mem_ctrl_t;

    typedef struct packed {
        logic                  regwrite;
        logic                  memtoreg;
        logic [REG_ADDR_W-1:0] rd;
        logic                  valid;
    } wb_ctrl_t;

    ex_ctrl_t  dec;
    ex_ctrl_t  id_ex_next;
    ex_ctrl_t  ex_q;
    mem_ctrl_t mem_q;
    wb_ctrl_t  wb_q;
    logic      use_rs1;
    logic      use_rs2;
    logic      ex_hit;
    logic      stall;
    logic      load_ex;
`ifdef ILLEGAL_OP_EN
    logic      id_illegal;
`endif

    always_comb begin
        dec     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
`ifdef ILLEGAL_OP_EN
        id_illegal = 1'b0;
`endif
        case (bus.opcode_id_i)
            7'b0110011: begin
                dec.aluop    = ALUOP_W'(2'b10);
                dec.regwrite = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            7'b0010011: begin
                dec.aluop    = ALUOP_W'(2'b11);
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                use_rs1      = 1'b1;
            end
            7'b0000011: begin
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.regwrite = 1'b1;
                dec.memtoreg = 1'b1;
                use_rs1      = 1'b1;
            end
            7'b0100011: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            7'b1100011: begin
                dec.aluop  = ALUOP_W'(2'b01);
                dec.branch = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            default: begin
`ifdef ILLEGAL_OP_EN
                id_illegal = 1'b1;
`endif
            end
        endcase
        // Undefined opcodes still occupy a slot (valid=1) but have no side effects.
        dec.valid = 1'b1;
        dec.rd    = dec.regwrite ? bus.rd_id_i : '0;
    end

    // Load-use: the load in EX cannot forward its data in time for an ID consumer.
    always_comb begin
        ex_hit = ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                 ((use_rs1 & (ex_q.rd == bus.rs1_id_i)) |
                  (use_rs2 & (ex_q.rd == bus.rs2_id_i)));
        stall   = (LOAD_USE_STALL != 0) & bus.id_valid_i & ~bus.flush_i & ex_hit;
        load_ex = bus.id_valid_i & ~bus.flush_i & ~stall;
        id_ex_next = load_ex ? dec : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q <= id_ex_next;
            if (bus.flush_i) begin
                mem_q <= '0;
            end else begin
                mem_q <= '{branch:   ex_q.branch,
                           memread:  ex_q.memread,
                           memwrite: ex_q.memwrite,
                           regwrite: ex_q.regwrite,
                           memtoreg: ex_q.memtoreg,
                           rd:       ex_q.rd,
                           valid:    ex_q.valid};
            end
            wb_q <= '{regwrite: mem_q.regwrite,
                      memtoreg: mem_q.memtoreg,
                      rd:       mem_q.rd,
                      valid:    mem_q.valid};
        end
    end

`ifdef ILLEGAL_OP_EN
    logic ex_ill;
    logic mem_ill;
    logic wb_ill;
    logic sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ill   <= 1'b0;
            mem_ill  <= 1'b0;
            wb_ill   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            ex_ill   <= load_ex & id_illegal;
            mem_ill  <= ~bus.flush_i & ex_ill;
            wb_ill   <= mem_ill;
            sticky_q <= sticky_q | wb_ill;
        end
    end

    assign bus.wb_illegal_o     = wb_ill;
    assign bus.illegal_sticky_o = sticky_q | wb_ill;
`else
    assign bus.wb_illegal_o     = 1'b0;
    assign bus.illegal_sticky_o = 1'b0;
`endif

    assign bus.stall_o        = stall;
    assign bus.ex_aluop_o     = ex_q.aluop;
    assign bus.ex_alusrc_o    = ex_q.alusrc;
    assign bus.ex_rd_o        = ex_q.rd;
    assign bus.mem_branch_o   = mem_q.branch;
    assign bus.mem_memread_o  = mem_q.memread;
    assign bus.mem_memwrite_o = mem_q.memwrite;
    assign bus.mem_rd_o       = mem_q.rd;
    assign bus.mem_regwrite_o = mem_q.regwrite;
    assign bus.wb_rd_o        = wb_q.rd;
    assign bus.wb_regwrite_o  = wb_q.regwrite;
    assign bus.wb_memtoreg_o  = wb_q.memtoreg;
    assign bus.wb_valid_o     = wb_q.valid;
endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Testbench for ctrl_pipe_unit: directed scenarios plus randomized traffic checked against
// a stage-history reference model. Honors ILLEGAL_OP_EN when defined.
module tb_ctrl_pipe_unit;
    localparam int AW = 2;
    localparam int RW = 5;
`ifdef ILLEGAL_OP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_X = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ctrl_pipe_unit_if #(.ALUOP_W(AW), .REG_ADDR_W(RW)) bus_if ();

    ctrl_pipe_unit #(.ALUOP_W(AW), .REG_ADDR_W(RW), .LOAD_USE_STALL(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int aluop;
        bit alusrc, branch, memread, memwrite, regwrite, memtoreg;
        int rd;
        bit valid, illegal;
    } stage_t;

    stage_t m_ex, m_mem, m_wb;
    bit     m_sticky;
    int     checks = 0;
    int     failures = 0;
    bit     obs_stall;
    bit     exp_stall;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction-class table: what each opcode asks of later stages and which sources it reads.
    function automatic stage_t decode(input logic [6:0] op, input int rd, output bit u1, output bit u2);
        stage_t s = '{default: 0};
        u1 = 0;
        u2 = 0;
        case (op)
            OP_R: begin s.aluop = 2; s.regwrite = 1; u1 = 1; u2 = 1; end
            OP_I: begin s.aluop = 3; s.alusrc = 1; s.regwrite = 1; u1 = 1; end
            OP_L: begin s.alusrc = 1; s.memread = 1; s.regwrite = 1; s.memtoreg = 1; u1 = 1; end
            OP_S: begin s.alusrc = 1; s.memwrite = 1; u1 = 1; u2 = 1; end
            OP_B: begin s.aluop = 1; s.branch = 1; u1 = 1; u2 = 1; end
            default: s.illegal = 1;
        endcase
        s.valid = 1;
        s.rd = s.regwrite ? rd : 0;
        return s;
    endfunction

    task automatic resetModel();
        m_ex = '{default: 0};
        m_mem = '{default: 0};
        m_wb = '{default: 0};
        m_sticky = 0;
    endtask

    task automatic checkAll(input bit stall_exp);
        checkOutput("stall", 32'(bus_if.stall_o), 32'(stall_exp));
        checkOutput("ex_aluop", 32'(bus_if.ex_aluop_o), 32'(m_ex.aluop));
        checkOutput("ex_alusrc", 32'(bus_if.ex_alusrc_o), 32'(m_ex.alusrc));
        checkOutput("ex_rd", 32'(bus_if.ex_rd_o), 32'(m_ex.rd));
        checkOutput("mem_branch", 32'(bus_if.mem_branch_o), 32'(m_mem.branch));
        checkOutput("mem_memread", 32'(bus_if.mem_memread_o), 32'(m_mem.memread));
        checkOutput("mem_memwrite", 32'(bus_if.mem_memwrite_o), 32'(m_mem.memwrite));
        checkOutput("mem_regwrite", 32'(bus_if.mem_regwrite_o), 32'(m_mem.regwrite));
        checkOutput("mem_rd", 32'(bus_if.mem_rd_o), 32'(m_mem.rd));
        checkOutput("wb_regwrite", 32'(bus_if.wb_regwrite_o), 32'(m_wb.regwrite));
        checkOutput("wb_memtoreg", 32'(bus_if.wb_memtoreg_o), 32'(m_wb.memtoreg));
        checkOutput("wb_rd", 32'(bus_if.wb_rd_o), 32'(m_wb.rd));
        checkOutput("wb_valid", 32'(bus_if.wb_valid_o), 32'(m_wb.valid));
        checkOutput("wb_illegal", 32'(bus_if.wb_illegal_o), 32'(ILL_EN & m_wb.illegal));
        checkOutput("sticky", 32'(bus_if.illegal_sticky_o), 32'(ILL_EN & (m_sticky | m_wb.illegal)));
    endtask

    // Drive one ID slot at negedge, check the whole pipe, then advance the model at posedge.
    task automatic applyStimulus(input bit v, input logic [6:0] op, input int rs1, input int rs2,
                                 input int rd, input bit fl);
        stage_t d;
        bit u1, u2;
        @(negedge clk);
        bus_if.id_valid_i  = v;
        bus_if.opcode_id_i = op;
        bus_if.rs1_id_i    = RW'(rs1);
        bus_if.rs2_id_i    = RW'(rs2);
        bus_if.rd_id_i     = RW'(rd);
        bus_if.flush_i     = fl;
        #1;
        d = decode(op, rd, u1, u2);
        exp_stall = v && !fl && m_ex.valid && m_ex.memread && m_ex.rd != 0 &&
                    ((u1 && m_ex.rd == rs1) || (u2 && m_ex.rd == rs2));
        obs_stall = bus_if.stall_o;
        checkAll(exp_stall);
        @(posedge clk);
        if (m_wb.illegal) m_sticky = 1;
        m_wb = m_mem;
        m_mem = fl ? '{default: 0} : m_ex;
        m_ex = (fl || exp_stall || !v) ? '{default: 0} : d;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 7'd0, 0, 0, 0, 0);
    endtask

    initial begin
        bit hold_v, hold_fl;
        logic [6:0] hold_op;
        int hold_r1, hold_r2, hold_rd;
        logic [6:0] ops [6];
        ops = '{OP_R, OP_I, OP_L, OP_S, OP_B, OP_X};

        bus_if.id_valid_i = 0;
        bus_if.opcode_id_i = 0;
        bus_if.rs1_id_i = 0;
        bus_if.rs2_id_i = 0;
        bus_if.rd_id_i = 0;
        bus_if.flush_i = 0;
        resetModel();
        #1;
        checkAll(0);
        @(negedge clk);
        rst_n = 1;

        // R-type latency through EX, MEM, WB.
        applyStimulus(1, OP_R, 1, 2, 5, 0);
        checkOutput("r_ex_aluop", 32'(bus_if.ex_aluop_o), 32'd2);
        idle();
        checkOutput("r_mem_regwrite", 32'(bus_if.mem_regwrite_o), 32'd1);
        checkOutput("r_mem_rd", 32'(bus_if.mem_rd_o), 32'd5);
        idle();
        checkOutput("r_wb_regwrite", 32'(bus_if.wb_regwrite_o), 32'd1);
        checkOutput("r_wb_memtoreg", 32'(bus_if.wb_memtoreg_o), 32'd0);

        // Load-use: one stall cycle, then the consumer enters EX.
        applyStimulus(1, OP_L, 1, 0, 7, 0);
        applyStimulus(1, OP_R, 2, 7, 8, 0);
        checkOutput("lu_stall", 32'(obs_stall), 32'd1);
        checkOutput("lu_bubble_rd", 32'(bus_if.ex_rd_o), 32'd0);
        applyStimulus(1, OP_R, 2, 7, 8, 0);
        checkOutput("lu_stall_once", 32'(obs_stall), 32'd0);
        checkOutput("lu_ex_aluop", 32'(bus_if.ex_aluop_o), 32'd2);

        // x0 destination and unused rs2 never stall.
        applyStimulus(1, OP_L, 1, 0, 0, 0);
        applyStimulus(1, OP_R, 0, 4, 9, 0);
        checkOutput("x0_stall", 32'(obs_stall), 32'd0);
        applyStimulus(1, OP_L, 1, 0, 3, 0);
        applyStimulus(1, OP_I, 1, 3, 9, 0);
        checkOutput("unused_rs2_stall", 32'(obs_stall), 32'd0);

        // Flush coinciding with a load-use condition.
        applyStimulus(1, OP_R, 1, 2, 4, 0);
        applyStimulus(1, OP_L, 1, 0, 7, 0);
        applyStimulus(1, OP_R, 7, 2, 6, 1);
        checkOutput("flush_stall", 32'(obs_stall), 32'd0);
        checkOutput("flush_ex_rd", 32'(bus_if.ex_rd_o), 32'd0);
        checkOutput("flush_mem_memread", 32'(bus_if.mem_memread_o), 32'd0);
        checkOutput("flush_wb_rd", 32'(bus_if.wb_rd_o), 32'd4);

        // Undefined opcode travels to WB as a side-effect-free slot.
        applyStimulus(1, OP_X, 1, 2, 10, 0);
        idle();
        idle();
        checkOutput("ill_wb_valid", 32'(bus_if.wb_valid_o), 32'd1);
        checkOutput("ill_wb_illegal", 32'(bus_if.wb_illegal_o), 32'(ILL_EN));
        idle();
        checkOutput("ill_sticky", 32'(bus_if.illegal_sticky_o), 32'(ILL_EN));
        checkOutput("ill_pulse_gone", 32'(bus_if.wb_illegal_o), 32'd0);

        // Asynchronous reset with a load sitting in MEM.
        applyStimulus(1, OP_L, 1, 0, 12, 0);
        idle();
        checkOutput("rst_pre_memread", 32'(bus_if.mem_memread_o), 32'd1);
        #2;
        rst_n = 0;
        #1;
        resetModel();
        checkAll(0);
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic; a stalled instruction is held and re-presented.
        hold_v = 0; hold_op = 0; hold_r1 = 0; hold_r2 = 0; hold_rd = 0; hold_fl = 0;
        for (int n = 0; n < 600; n++) begin
            if (!exp_stall || n == 0) begin
                hold_v  = ($urandom_range(0, 7) != 0);
                hold_op = ops[$urandom_range(0, 5)];
                if ($urandom_range(0, 9) == 0) hold_op = 7'($urandom_range(0, 127));
                hold_r1 = $urandom_range(0, 3);
                hold_r2 = $urandom_range(0, 3);
                hold_rd = $urandom_range(0, 3);
            end
            hold_fl = ($urandom_range(0, 9) == 0);
            applyStimulus(hold_v, hold_op, hold_r1, hold_r2, hold_rd, hold_fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
